// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the RV32 pipeline hazard controller.
//   - state_t   : controller FSM states (RUN / REDIRECT)
//   - NOP_INSTR : instruction word the IF/ID register loads when flushed (addi x0,x0,0)
//   - REG_X0    : hard-wired zero register; never a real hazard source
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  REG_X0    = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Purely combinational load-use hazard compare. Flags when the EX-stage
//   instruction is a load whose destination is read by the ID-stage instruction.
//   Ports:
//     id_rs1, id_rs2         in  ID-stage source registers
//     id_use_rs1, id_use_rs2 in  ID instruction actually reads rs1 / rs2
//     ex_rd                  in  EX-stage destination register
//     ex_mem_read            in  EX-stage instruction is a load
//     load_use               out hazard: ID must wait one cycle for the load data
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // A load targeting x0 writes nothing, so it can never create a dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_X0)) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequences the 5-stage RV32 pipeline registers: PC enable, IF/ID enable/flush,
//   ID/EX bubble and EX/MEM freeze. Resolves load-use stalls, EX redirects,
//   fetch wait states and data-memory busy freezes; counts stall and flush cycles.
//   Outputs are combinational from registered state plus current inputs so the
//   pipeline registers act on them in the same cycle.
//   Ports:
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     id_rs1/id_rs2/id_use_*   ID-stage operand usage
//     ex_rd, ex_mem_read       EX-stage load destination
//     ex_redirect              EX resolved a taken branch/jump
//     imem_ready               fetch data valid this cycle
//     dmem_busy                MEM stage cannot complete this cycle
//     pc_en, if_id_en          PC / IF-ID load enables
//     if_id_flush              IF/ID loads NOP (wins over if_id_en)
//     id_ex_flush              ID/EX loads a bubble
//     ex_mem_en                EX/MEM and MEM/WB load enable
//     stall_cnt, flush_cnt     wrapping perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Remaining wrong-path cycles to discard after the redirect cycle itself.
  localparam logic [3:0] RD_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state,     state_nxt;
  logic [3:0] rd_cnt,    rd_cnt_nxt;
  logic       stall_inc;
  logic       flush_inc;
  logic       load_use;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (dmem_busy) begin
      // Whole pipeline freezes; a pending redirect stays in EX and is seen once MEM frees up.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (state == ST_RUN) begin
      if (ex_redirect) begin
        // Redirect outranks load-use: the stalled ID instruction is on the wrong path anyway.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt  = ST_REDIRECT;
          rd_cnt_nxt = RD_RELOAD;
        end
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        stall_inc   = 1'b1;
      end else if (!imem_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        stall_inc   = 1'b1;
      end
    end else begin
      if_id_flush = 1'b1;
      pc_en       = imem_ready;
      flush_inc   = 1'b1;
      if (ex_redirect) begin
        id_ex_flush = 1'b1;
        rd_cnt_nxt  = RD_RELOAD;
      end else begin
        rd_cnt_nxt = rd_cnt - 4'd1;
        if (rd_cnt == 4'd1) state_nxt = ST_RUN;
      end
    end

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      rd_cnt    <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_busy;

  logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_en_a;
  logic [3:0]  stall_cnt_a, flush_cnt_a;
  logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_en_b;
  logic [31:0] stall_cnt_b, flush_cnt_b;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en}
  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_en_a};
  assign ctl_b = {pc_en_b, if_id_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_en_b};

  localparam logic [4:0] CTL_RST   = 5'b00110;
  localparam logic [4:0] CTL_RUN   = 5'b11001;
  localparam logic [4:0] CTL_LU    = 5'b00011;
  localparam logic [4:0] CTL_REDIR = 5'b11111;
  localparam logic [4:0] CTL_RDSEQ = 5'b11101;
  localparam logic [4:0] CTL_BUSY  = 5'b00000;
  localparam logic [4:0] CTL_IWAIT = 5'b01101;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_en(ex_mem_en_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .dmem_busy(dmem_busy), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_en(ex_mem_en_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_redirect = 1'($urandom); imem_ready = 1'($urandom); dmem_busy = 1'($urandom);
      #1;
      n_vec++;
      if (ctl_a !== CTL_RST) begin
        n_err++; $display("FAIL reset_ctl_%0d: got %b want %b", c, ctl_a, CTL_RST);
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN || stall_cnt_a !== 4'd0 || flush_cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release: ctl %b stall %0d flush %0d, want %b 0 0",
               ctl_a, stall_cnt_a, flush_cnt_a, CTL_RUN);
    end
    n_vec++;
    if (stall_cnt_b !== 32'd0 || flush_cnt_b !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt_b: stall %0d flush %0d, want 0 0", stall_cnt_b, flush_cnt_b);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    n_vec++;
    if (ctl_a !== CTL_LU) begin
      n_err++; $display("FAIL load_use_ctl: got %b want %b", ctl_a, CTL_LU);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN || stall_cnt_a !== 4'd1) begin
      n_err++; $display("FAIL load_use_after: ctl %b stall %0d, want %b 1", ctl_a, stall_cnt_a, CTL_RUN);
    end
    // Load into x0 must not stall even though rs2 also names x0.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN) begin
      n_err++; $display("FAIL load_use_x0: got %b want %b", ctl_a, CTL_RUN);
    end
    tick();
    // Matching rs1 that the instruction does not read is not a hazard.
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN) begin
      n_err++; $display("FAIL load_use_unused_rs1: got %b want %b", ctl_a, CTL_RUN);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (stall_cnt_a !== 4'd1) begin
      n_err++; $display("FAIL load_use_no_extra: stall %0d want 1", stall_cnt_a);
    end
  endtask

  task automatic test_redirect();
    logic [4:0] exp_seq [4];
    exp_seq[0] = CTL_REDIR; exp_seq[1] = CTL_RDSEQ; exp_seq[2] = CTL_RDSEQ; exp_seq[3] = CTL_RUN;
    do_reset();
    ex_redirect = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (ctl_a !== exp_seq[c] || flush_cnt_a !== 4'(c)) begin
        n_err++;
        $display("FAIL redirect_c%0d: ctl %b flush %0d, want %b %0d", c, ctl_a, flush_cnt_a, exp_seq[c], c);
      end
      if (c == 1) begin
        n_vec++;
        if (ctl_b !== CTL_RUN || flush_cnt_b !== 32'd1) begin
          n_err++; $display("FAIL redirect_single: ctl %b flush %0d, want %b 1", ctl_b, flush_cnt_b, CTL_RUN);
        end
      end
      tick();
      ex_redirect = 1'b0;
    end
  endtask

  task automatic test_redirect_busy();
    do_reset();
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    tick();
    dmem_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (ctl_a !== CTL_BUSY || flush_cnt_a !== 4'd2) begin
        n_err++; $display("FAIL redir_busy_c%0d: ctl %b flush %0d, want %b 2", c, ctl_a, flush_cnt_a, CTL_BUSY);
      end
      tick();
    end
    dmem_busy = 1'b0;
    imem_ready = 1'b0;
    #1;
    n_vec++;
    if (ctl_a !== CTL_IWAIT) begin
      n_err++; $display("FAIL redir_last_iwait: got %b want %b", ctl_a, CTL_IWAIT);
    end
    tick();
    imem_ready = 1'b1;
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN || flush_cnt_a !== 4'd3 || stall_cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL redir_busy_end: ctl %b flush %0d stall %0d, want %b 3 0", ctl_a, flush_cnt_a, stall_cnt_a, CTL_RUN);
    end
  endtask

  task automatic test_busy_run();
    do_reset();
    dmem_busy = 1'b1; ex_redirect = 1'b1; imem_ready = 1'b0;
    #1;
    n_vec++;
    if (ctl_a !== CTL_BUSY) begin
      n_err++; $display("FAIL busy_run_ctl: got %b want %b", ctl_a, CTL_BUSY);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN || flush_cnt_a !== 4'd0 || stall_cnt_a !== 4'd0) begin
      n_err++;
      $display("FAIL busy_run_hold: ctl %b flush %0d stall %0d, want %b 0 0", ctl_a, flush_cnt_a, stall_cnt_a, CTL_RUN);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    n_vec++;
    if (ctl_a !== CTL_REDIR) begin
      n_err++; $display("FAIL simul_ctl: got %b want %b", ctl_a, CTL_REDIR);
    end
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (stall_cnt_a !== 4'd0 || flush_cnt_a !== 4'd1) begin
      n_err++; $display("FAIL simul_cnt: stall %0d flush %0d, want 0 1", stall_cnt_a, flush_cnt_a);
    end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    ex_redirect = 1'b1;
    tick();
    do_reset();
    #1;
    n_vec++;
    if (ctl_a !== CTL_RUN || flush_cnt_a !== 4'd0) begin
      n_err++; $display("FAIL reset_mid_redirect: ctl %b flush %0d, want %b 0", ctl_a, flush_cnt_a, CTL_RUN);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b0;
    #1;
    n_vec++;
    if (ctl_a !== CTL_IWAIT) begin
      n_err++; $display("FAIL wrap_ctl: got %b want %b", ctl_a, CTL_IWAIT);
    end
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 15 || c == 16 || c == 17) begin
        n_vec++;
        if (stall_cnt_a !== 4'(c)) begin
          n_err++; $display("FAIL wrap_c%0d: stall %0d want %0d", c, stall_cnt_a, 4'(c));
        end
      end
    end
    n_vec++;
    if (stall_cnt_b !== 32'd17) begin
      n_err++; $display("FAIL wrap_wide: stall %0d want 17", stall_cnt_b);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_busy();
    test_busy_run();
    test_simultaneous();
    test_reset_mid_redirect();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
